// File: rtl/serial2mem_if.sv
// Byte-in / memory-write bus between the UART RX side and the record RAM.
//
// Handshake semantics: uart_valid is a one-cycle strobe with no ready path,
// so the receiver has no backpressure and every strobed byte is consumed.
// write_en is a one-cycle write strobe that the memory always takes.
// Flow control is per record only: write_full is sampled once, when the
// sync prefix completes, and decides whether that record is stored or dropped.
interface serial2mem_if #(
  parameter int AW = 16
);
  logic [7:0]    uart_data;
  logic          uart_valid;
  logic          write_full;
  logic [AW-1:0] write_addr;
  logic [7:0]    write_data;
  logic          write_en;
  logic          write_done;

  // Upstream side: UART receiver and record consumer
  modport master (
    output uart_data, uart_valid, write_full,
    input  write_addr, write_data, write_en, write_done
  );

  // The record writer itself
  modport slave (
    input  uart_data, uart_valid, write_full,
    output write_addr, write_data, write_en, write_done
  );
endinterface

// File: rtl/serial2mem.sv
// Hunts for the 0xFF 0xFF sync prefix in a UART byte stream and writes the
// following 8 bytes into an 8-byte record slot of the record RAM.
module serial2mem #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic          clock,
  input  logic          reset,
  serial2mem_if.slave   bus,
  output logic [AW-4:0] record_index,
  output logic [7:0]    drop_count,
  output logic [7:0]    timeout_count,
  output logic [1:0]    state_dbg
);

  localparam int GW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] HUNT1 = 2'd0;
  localparam logic [1:0] HUNT2 = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]    state;
  logic [2:0]    byte_idx;
  logic [GW-1:0] gap_cnt;

  // Current FSM state is exposed for debug and checkers
  assign state_dbg = state;

  // Sync hunt, record write/drop sequencing, inter-byte timeout and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= HUNT1;
      byte_idx      <= 3'd0;
      gap_cnt       <= '0;
      record_index  <= '0;
      drop_count    <= 8'd0;
      timeout_count <= 8'd0;
      bus.write_en   <= 1'b0;
      bus.write_done <= 1'b0;
      bus.write_addr <= '0;
      bus.write_data <= 8'd0;
    end else begin
      bus.write_en   <= 1'b0;
      bus.write_done <= 1'b0;

      // The slot advances the cycle after write_done, so the last write of a
      // record still addresses the slot it belongs to.
      if (bus.write_done) begin
        record_index <= record_index + (AW-3)'(1);
      end

      case (state)
        HUNT1: begin
          gap_cnt <= '0;
          if (bus.uart_valid && bus.uart_data == 8'hFF) begin
            state <= HUNT2;
          end
        end

        HUNT2: begin
          gap_cnt <= '0;
          if (bus.uart_valid) begin
            if (bus.uart_data == 8'hFF) begin
              byte_idx <= 3'd0;
              state    <= bus.write_full ? DROP : DATA;
            end else begin
              state <= HUNT1;
            end
          end
        end

        DATA, DROP: begin
          if (bus.uart_valid) begin
            gap_cnt  <= '0;
            byte_idx <= byte_idx + 3'd1;
            if (state == DATA) begin
              // 0xFF is plain payload here; there is no escaping
              bus.write_en   <= 1'b1;
              bus.write_data <= bus.uart_data;
              bus.write_addr <= {record_index, byte_idx};
            end
            if (byte_idx == 3'd7) begin
              state <= HUNT1;
              if (state == DATA) begin
                bus.write_done <= 1'b1;
              end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
              end
            end
          end else if (gap_cnt == GW'(TIMEOUT)) begin
            // Abort: the partial slot is simply overwritten by the next record
            state   <= HUNT1;
            gap_cnt <= '0;
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 8'd1;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: begin
          state   <= HUNT1;
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial2mem.sv
// Self-checking bench for serial2mem: directed sequences from the test plan,
// a randomized phase, drop saturation and an asynchronous reset mid-record.
module tb_serial2mem;

  localparam int AW      = 6;
  localparam int TIMEOUT = 16;
  localparam int NREC    = 1 << (AW - 3);
  localparam int EW      = 1 + AW + 8;

  logic clock;
  logic reset;

  logic [AW-4:0] record_index;
  logic [7:0]    drop_count;
  logic [7:0]    timeout_count;
  logic [1:0]    state_dbg;

  serial2mem_if #(.AW(AW)) bus ();

  serial2mem #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .record_index  (record_index),
    .drop_count    (drop_count),
    .timeout_count (timeout_count),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // Expected writes, {done, addr, data}
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Frame-level view of the stream: "pos" is the position inside a frame
  // (-1 when not inside one), "seen_ff" remembers a lone 0xFF while hunting.
  int m_rec;
  int m_pos;
  bit m_dropping;
  bit m_seen_ff;
  int m_drops;
  int m_timeouts;

  function automatic void model_reset();
    m_rec = 0; m_pos = -1; m_dropping = 0; m_seen_ff = 0;
    m_drops = 0; m_timeouts = 0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit full);
    logic [AW-1:0] a;
    if (m_pos >= 0) begin
      if (!m_dropping) begin
        a = AW'(m_rec * 8 + m_pos);
        exp_q.push_back({(m_pos == 7), a, b});
      end
      m_pos++;
      if (m_pos == 8) begin
        m_pos = -1;
        if (m_dropping) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        else            m_rec = (m_rec + 1) % NREC;
      end
    end else if (b == 8'hFF) begin
      if (m_seen_ff) begin
        m_seen_ff  = 0;
        m_pos      = 0;
        m_dropping = full;
      end else begin
        m_seen_ff = 1;
      end
    end else begin
      m_seen_ff = 0;
    end
  endfunction

  function automatic void model_idle(input int n);
    if (n > TIMEOUT && m_pos >= 0) begin
      m_pos      = -1;
      m_timeouts = (m_timeouts < 255) ? m_timeouts + 1 : 255;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic put(input logic [7:0] b, input bit full);
    @(negedge clock);
    bus.uart_data  = b;
    bus.uart_valid = 1'b1;
    bus.write_full = full;
    model_byte(b, full);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.uart_valid = 1'b0;
      bus.write_full = 1'b0;
    end
    model_idle(n);
  endtask

  task automatic put_record(input logic [7:0] base, input bit full);
    put(8'hFF, full);
    put(8'hFF, full);
    for (int i = 0; i < 8; i++) put(base + 8'(i), full);
  endtask

  task automatic check_counters(input string tag);
    idle(2);
    check({tag, "_record_index"},  record_index,  m_rec);
    check({tag, "_drop_count"},    drop_count,    m_drops);
    check({tag, "_timeout_count"}, timeout_count, m_timeouts);
    check({tag, "_pending"},       exp_q.size(),  0);
  endtask

  // ---------------- write monitor ----------------
  // Every write strobe must match the oldest expected write
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset && bus.write_en) begin
      check("write_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_addr", bus.write_addr, e[EW-2:8]);
        check("write_data", bus.write_data, e[7:0]);
        check("write_done", bus.write_done, e[EW-1]);
      end
    end else if (reset && bus.write_done) begin
      check("done_without_en", bus.write_en, 1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    bit full;

    reset          = 1'b0;
    bus.uart_data  = 8'd0;
    bus.uart_valid = 1'b0;
    bus.write_full = 1'b0;
    model_reset();

    repeat (3) @(negedge clock);
    check("rst_write_en",      bus.write_en,   0);
    check("rst_write_done",    bus.write_done, 0);
    check("rst_write_addr",    bus.write_addr, 0);
    check("rst_write_data",    bus.write_data, 0);
    check("rst_record_index",  record_index,   0);
    check("rst_drop_count",    drop_count,     0);
    check("rst_timeout_count", timeout_count,  0);
    check("rst_state",         state_dbg,      0);
    reset = 1'b1;

    // Basic record: FF FF 00 11 .. 77, back-to-back
    put(8'hFF, 0); put(8'hFF, 0);
    for (int i = 0; i < 8; i++) put(8'(i * 8'h11), 0);
    check_counters("rec0");

    // Stray bytes and a broken prefix before a good one
    put(8'h12, 0); put(8'hFF, 0); put(8'h34, 0);
    put_record(8'hA0, 0);
    check_counters("rec1");

    // Third FF is payload byte 0
    put(8'hFF, 0); put(8'hFF, 0); put(8'hFF, 0);
    for (int i = 1; i < 8; i++) put(8'(i), 0);
    check_counters("ff_payload");

    // Dropped record, then the next one lands in the unchanged slot
    put_record(8'hC0, 1);
    check_counters("drop");
    check("drop_state_hunt", state_dbg, 0);
    put_record(8'hD0, 0);
    check_counters("after_drop");

    // Timeout after 3 bytes, then a full record reuses the slot
    put(8'hFF, 0); put(8'hFF, 0);
    put(8'h51, 0); put(8'h52, 0); put(8'h53, 0);
    idle(TIMEOUT + 10);
    check("timeout_state_hunt", state_dbg, 0);
    check_counters("timeout");
    put_record(8'hE0, 0);
    check_counters("after_timeout");

    // Timeout while dropping does not count as a drop
    put(8'hFF, 1); put(8'hFF, 1); put(8'h01, 1);
    idle(TIMEOUT + 10);
    check_counters("drop_timeout");

    // Randomized traffic with junk, random write_full and short gaps
    for (int r = 0; r < 24; r++) begin
      for (int j = 0; j < $urandom_range(0, 3); j++) put(8'($urandom_range(0, 255)), 0);
      full = ($urandom_range(0, 3) == 0);
      put(8'hFF, full); put(8'hFF, full);
      for (int i = 0; i < 8; i++) begin
        b = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        put(b, full);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
      end
    end
    idle(TIMEOUT + 10);
    check_counters("random");

    // Drop counter saturates at 255
    for (int r = 0; r < 260; r++) put_record(8'h00, 1);
    check_counters("drop_sat");
    check("drop_sat_value", drop_count, 255);

    // Asynchronous reset in the middle of a record
    put(8'hFF, 0); put(8'hFF, 0);
    for (int i = 0; i < 4; i++) put(8'h90 + 8'(i), 0);
    idle(1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_write_en",      bus.write_en,   0);
    check("mid_rst_write_addr",    bus.write_addr, 0);
    check("mid_rst_write_data",    bus.write_data, 0);
    check("mid_rst_record_index",  record_index,   0);
    check("mid_rst_drop_count",    drop_count,     0);
    check("mid_rst_timeout_count", timeout_count,  0);
    check("mid_rst_state",         state_dbg,      0);
    check("mid_rst_pending",       exp_q.size(),   0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    put_record(8'h40, 0);
    check_counters("after_reset");

    check("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
